// File: rtl/crc_bit_serializer.sv
// Parallel-to-serial CRC output stage, LSB-first (reflected) or MSB-first per word.
// Define CRC_SER_XOROUT_EN to add the load_xorout final-XOR input.
module crc_bit_serializer #(
    parameter int unsigned MAX_BITS      = 32,
    parameter int unsigned MAX_BIT_COUNT = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [MAX_BITS-1:0]      load_value,
    input  logic [MAX_BIT_COUNT-1:0] load_width_m1,
    input  logic                     load_lsb_first,
`ifdef CRC_SER_XOROUT_EN
    input  logic [MAX_BITS-1:0]      load_xorout,
`endif
    output logic                     bit_out,
    output logic                     bit_valid,
    input  logic                     bit_ready,
    output logic                     bit_last,
    output logic                     busy
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [MAX_BIT_COUNT-1:0] TOP_IDX = MAX_BIT_COUNT'(MAX_BITS - 1);

    state_t                   state;
    logic [MAX_BITS-1:0]      shreg;
    logic [MAX_BIT_COUNT-1:0] cnt;
    logic                     dir;

    logic [MAX_BIT_COUNT-1:0] align;
    logic [MAX_BITS-1:0]      word;

    always_comb begin
        align = TOP_IDX - load_width_m1;
`ifdef CRC_SER_XOROUT_EN
        word  = (load_value ^ load_xorout) & ({MAX_BITS{1'b1}} >> align);
`else
        // Bits above the width fall off the top (MSB-first) or are never reached (LSB-first).
        word  = load_value;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            dir   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        shreg <= load_lsb_first ? word : (word << align);
                        cnt   <= load_width_m1;
                        dir   <= load_lsb_first;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_ready) begin
                        shreg <= dir ? (shreg >> 1) : (shreg << 1);
                        cnt   <= cnt - 1'b1;
                        if (cnt == '0) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign load_ready = (state == IDLE);
    assign bit_valid  = (state == SHIFT);
    assign busy       = bit_valid;
    assign bit_out    = bit_valid & (dir ? shreg[0] : shreg[MAX_BITS-1]);
    assign bit_last   = bit_valid & (cnt == '0);

endmodule

// File: tb/tb_crc_bit_serializer.sv
// Directed self-checking bench for crc_bit_serializer; expected bit streams are hand-derived
// and written as vectors where bit i is the i-th bit on the wire.
module tb_crc_bit_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_value;
    logic [4:0]  load_width_m1;
    logic        load_lsb_first;
    logic [31:0] load_xorout;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready;
    logic        bit_last;
    logic        busy;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    crc_bit_serializer #(
        .MAX_BITS      (32),
        .MAX_BIT_COUNT (5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_value     (load_value),
        .load_width_m1  (load_width_m1),
        .load_lsb_first (load_lsb_first),
`ifdef CRC_SER_XOROUT_EN
        .load_xorout    (load_xorout),
`endif
        .bit_out        (bit_out),
        .bit_valid      (bit_valid),
        .bit_ready      (bit_ready),
        .bit_last       (bit_last),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".load_ready"}, 32'(load_ready), 32'd1);
        check({tag, ".bit_valid"},  32'(bit_valid),  32'd0);
        check({tag, ".bit_out"},    32'(bit_out),    32'd0);
        check({tag, ".bit_last"},   32'(bit_last),   32'd0);
        check({tag, ".busy"},       32'(busy),       32'd0);
    endtask

    task automatic load(input logic [31:0] value, input logic [4:0] w, input logic lsb);
        load_value     = value;
        load_width_m1  = w;
        load_lsb_first = lsb;
        load_valid     = 1'b1;
        tick();
        load_valid     = 1'b0;
        load_value     = '0;
    endtask

    // Receives w+1 bits; optionally stalls before bit stall_at and pokes load_valid mid-word.
    task automatic stream(input string tag, input logic [31:0] seq, input int unsigned w,
                          input int unsigned stall_at, input int unsigned stall_len,
                          input logic poke);
        bit_ready = 1'b1;
        for (int unsigned i = 0; i <= w; i++) begin
            if (i == stall_at && stall_len != 0) begin
                bit_ready = 1'b0;
                for (int unsigned s = 0; s < stall_len; s++) begin
                    check($sformatf("%s.stall%0d.bit_out", tag, s), 32'(bit_out), 32'(seq[i]));
                    check($sformatf("%s.stall%0d.bit_valid", tag, s), 32'(bit_valid), 32'd1);
                    check($sformatf("%s.stall%0d.bit_last", tag, s), 32'(bit_last), 32'(i == w));
                    tick();
                end
                bit_ready = 1'b1;
            end
            check($sformatf("%s.bit%0d.out", tag, i), 32'(bit_out), 32'(seq[i]));
            check($sformatf("%s.bit%0d.valid", tag, i), 32'(bit_valid), 32'd1);
            check($sformatf("%s.bit%0d.last", tag, i), 32'(bit_last), 32'(i == w));
            check($sformatf("%s.bit%0d.load_ready", tag, i), 32'(load_ready), 32'd0);
            if (poke && i != w) begin
                load_valid = 1'b1;
                load_value = 32'hFFFF_FFFF;
            end else begin
                load_valid = 1'b0;
                load_value = '0;
            end
            tick();
        end
        check_idle({tag, ".after"});
    endtask

    initial begin
        rst_n          = 1'b0;
        load_valid     = 1'b0;
        load_value     = '0;
        load_width_m1  = '0;
        load_lsb_first = 1'b0;
        load_xorout    = '0;
        bit_ready      = 1'b0;
        tick();
        tick();
        check_idle("reset");
        rst_n = 1'b1;
        tick();
        check_idle("post_reset");

        // 0xB5 reflected: 1,0,1,0,1,1,0,1
        load(32'h0000_00B5, 5'd7, 1'b1);
        stream("lsb8", 32'h0000_00B5, 7, 99, 0, 1'b0);

        // 0xB5 normal: 1,0,1,1,0,1,0,1
        load(32'h0000_00B5, 5'd7, 1'b0);
        stream("msb8", 32'h0000_00AD, 7, 99, 0, 1'b0);

        // 1, thirty zeros, 1
        load(32'h8000_0001, 5'd31, 1'b0);
        stream("full32", 32'h8000_0001, 31, 99, 0, 1'b0);

        // 0xA5C3 reflected: 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; stall showing bit 4
        load(32'h0000_A5C3, 5'd15, 1'b1);
        stream("bp16", 32'h0000_A5C3, 15, 4, 3, 1'b0);

        // upper bits masked, with load_valid held during SHIFT
        load(32'hFFFF_FF0F, 5'd3, 1'b1);
        stream("mask4", 32'h0000_000F, 3, 99, 0, 1'b1);

        load(32'h0000_0001, 5'd0, 1'b1);
        stream("single", 32'h0000_0001, 0, 99, 0, 1'b0);

        load(32'h0000_0001, 5'd0, 1'b0);
        stream("single_msb", 32'h0000_0001, 0, 99, 0, 1'b0);

        // reset while the 5th bit of a 32-bit word is presented
        load(32'hFFFF_FFFF, 5'd31, 1'b1);
        bit_ready = 1'b1;
        repeat (4) tick();
        check("midrst.bit_valid_before", 32'(bit_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle("midrst");
        load(32'h0000_00B5, 5'd7, 1'b1);
        stream("midrst.reload", 32'h0000_00B5, 7, 99, 0, 1'b0);

`ifdef CRC_SER_XOROUT_EN
        // 0x12 ^ 0xFF = 0xED reflected: 1,0,1,1,0,1,1,1
        load_xorout = 32'h0000_00FF;
        load(32'h0000_0012, 5'd7, 1'b1);
        load_xorout = '0;
        stream("xorout", 32'h0000_00ED, 7, 99, 0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/crc_bit_serializer.md
Name: crc_bit_serializer

Overview:
- Parallel-to-serial output stage for the CRC datapath.
- Accepts a computed CRC word of runtime-selectable width (1..MAX_BITS).
- Shifts the word out one bit per handshake, either LSB-first (reflected) or MSB-first (normal).
- Sits between the CRC result register and the bit-serial output pins; it is the sequential counterpart of the combinational input-side bit reflector.

Parameters:
- MAX_BITS, 32, widest supported CRC word.
- MAX_BIT_COUNT, 5, width of the width field; equals log2(MAX_BITS).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- load_valid  input  1  load_value/load_width_m1/load_lsb_first are valid.
- load_ready  output  1  block can accept a new word.
- load_value  input  MAX_BITS  word to serialize; bits above the selected width are ignored.
- load_width_m1  input  MAX_BIT_COUNT  word width minus 1 (0 means 1 bit, 31 means 32 bits).
- load_lsb_first  input  1  1 sends bit 0 first (reflected); 0 sends bit [width_m1] first.
- bit_out  output  1  current serial bit.
- bit_valid  output  1  bit_out is valid.
- bit_ready  input  1  consumer accepts bit_out this cycle.
- bit_last  output  1  current bit is the final bit of the word.
- busy  output  1  word in flight (equals bit_valid).

Behaviour:
- Reset: synchronous; rst_n low at a rising edge forces state IDLE.
  - Reset values: load_ready=1, bit_valid=0, bit_out=0, bit_last=0, busy=0.
  - Shift register and counter are cleared to 0.
- FSM states: IDLE and SHIFT.
- IDLE:
  - load_ready=1, bit_valid=0.
  - On load_valid=1, capture the word, go to SHIFT.
  - LSB-first capture: shreg=load_value.
  - MSB-first capture: shreg=load_value << (MAX_BITS-1-load_width_m1), left-aligned so the word MSB sits at shreg[MAX_BITS-1].
  - cnt=load_width_m1; dir=load_lsb_first.
- Latency: load accepted at edge N; first bit valid in the cycle after edge N. No combinational path from load to bit outputs.
- SHIFT:
  - load_ready=0, bit_valid=1.
  - bit_out=shreg[0] if dir=1, else shreg[MAX_BITS-1].
  - bit_last=(cnt==0).
- Transfer: occurs when bit_valid and bit_ready are both 1.
  - Shift shreg right (dir=1) or left (dir=0), zero fill.
  - cnt decrements.
  - If bit_last, go to IDLE.
- Backpressure: while bit_ready=0, bit_out, bit_last and all state hold stable. No bit is dropped or duplicated.
- Word boundary: load_ready rises the cycle after the last transfer, so there is exactly one idle cycle between words. load_valid while in SHIFT is ignored and not queued.
- Width handling:
  - Bits of load_value above load_width_m1 never appear on bit_out.
  - Exactly load_width_m1+1 transfers occur per word.
  - width_m1=0 gives a single-bit word with bit_last=1 on the first bit.
- Reset mid-word: the word is discarded; the next cycle has bit_valid=0 and load_ready=1.
- bit_ready is don't-care outside SHIFT.
- bit_out is driven 0 whenever bit_valid=0.

Optional Feature:
- Macro: CRC_SER_XOROUT_EN.
- When defined:
  - Adds input port load_xorout [MAX_BITS].
  - At capture, the loaded word is (load_value ^ load_xorout), masked to the selected width, before alignment. This implements the CRC final-XOR stage.
- When undefined: the port is absent and the word is serialized unmodified.
- Timing and handshake are identical in both builds.

Test Plan:
- LSB-first: load 0x000000B5, width_m1=7, lsb_first=1, bit_ready=1 -> bits 1,0,1,0,1,1,0,1 on 8 consecutive cycles; bit_last on the 8th; load_ready=1 on the following cycle.
- MSB-first: load 0x000000B5, width_m1=7, lsb_first=0 -> bits 1,0,1,1,0,1,0,1.
- Full width: load 0x80000001, width_m1=31, lsb_first=0 -> 1, then 30 zeros, then 1; 32 transfers; bit_last only on the 32nd.
- Backpressure: 16-bit word 0xA5C3, lsb_first=1, bit_ready low for 3 cycles after the 4th transfer -> bit_out holds 0 (bit 4) stable; resumed stream exactly matches the unstalled sequence.
- Width masking and single bit:
  - 0xFFFFFF0F, width_m1=3, lsb_first=1 -> bits 1,1,1,1 only.
  - 0x00000001, width_m1=0 -> one bit of 1 with bit_last=1.
  - load_valid asserted during SHIFT -> ignored.
- Reset mid-word: rst_n low for 1 cycle during the 5th bit of a 32-bit word -> next cycle bit_valid=0, busy=0, load_ready=1; a new load afterwards serializes correctly.
  - With CRC_SER_XOROUT_EN: 0x12 ^ 0xFF, width_m1=7, lsb_first=1 -> 0xED LSB-first: 1,0,1,1,0,1,1,1.
